laser_search_ctrl: RTL and testbench

Search scheduler for the LASER two-circle coverage engine. Counts incoming target points into the external point buffer, then sequences candidate circle-centre pairs into a shared hit-count datapath through a req/ack handshake. Uses alternating raster sweeps of C1 and C2 to find the best centre pair, then reports it with a one-cycle DONE.

---
 rtl/laser_search_ctrl.sv | 159 +++++++++++++++
 tb/tb_laser_search_ctrl.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/laser_search_ctrl.sv
// laser_search_ctrl: counts target points into the point buffer, then walks
// candidate centre pairs through the shared hit-count datapath using
// alternating raster sweeps of C1 and C2, keeping the best pair seen.
// Optional build macro: LASER_EARLY_EXIT_EN ends the search as soon as a
// candidate covers all NPTS points.
module laser_search_ctrl #(
  parameter int unsigned NPTS     = 40,
  parameter int unsigned MAX_PASS = 4
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       in_valid,
  output logic       buf_we,
  output logic [5:0] buf_addr,
  output logic       eval_req,
  output logic [3:0] eval_c1x,
  output logic [3:0] eval_c1y,
  output logic [3:0] eval_c2x,
  output logic [3:0] eval_c2y,
  input  logic       eval_ack,
  input  logic [5:0] eval_hits,
  output logic [3:0] C1X,
  output logic [3:0] C1Y,
  output logic [3:0] C2X,
  output logic [3:0] C2Y,
  output logic [5:0] best_hits,
  output logic       DONE
);

  typedef enum logic [2:0] {LOAD, SWEEP1, SWEEP2, CHECK, FINISH} state_t;

  state_t     state;
  state_t     state_next;

  logic [5:0] load_cnt;
  logic [7:0] scan;       // {y, x}: x in the low nibble so x runs fastest
  logic [7:0] pass_cnt;
  logic       improved;

  logic       load_last;
  logic       ack_fire;
  logic       better;
  logic       scan_last;
  logic       pass_last;
  logic       full_hit;
  logic       check_stop;

  assign buf_addr  = load_cnt;
  assign load_last = (state == LOAD) && in_valid && (load_cnt == 6'(NPTS - 1));
  assign ack_fire  = eval_req && eval_ack;
  assign better    = eval_hits > best_hits;
  assign scan_last = (scan == 8'hFF);
  assign pass_last = ((pass_cnt + 8'd1) == 8'(MAX_PASS));

`ifdef LASER_EARLY_EXIT_EN
  // best_hits can only reach NPTS via an early-exit ack, so it marks that case in CHECK
  assign full_hit   = better && (eval_hits == 6'(NPTS));
  assign check_stop = !improved || pass_last || (best_hits == 6'(NPTS));
`else
  assign full_hit   = 1'b0;
  assign check_stop = !improved || pass_last;
`endif

  // State register
  always_ff @(posedge CLK) begin
    if (RST) state <= LOAD;
    else     state <= state_next;
  end

  // Next-state selection
  always_comb begin
    state_next = state;
    case (state)
      LOAD:    if (load_last) state_next = SWEEP1;
      SWEEP1:  if (ack_fire) begin
                 if (full_hit)       state_next = CHECK;
                 else if (scan_last) state_next = SWEEP2;
               end
      SWEEP2:  if (ack_fire && (full_hit || scan_last)) state_next = CHECK;
      CHECK:   state_next = check_stop ? FINISH : SWEEP1;
      FINISH:  state_next = LOAD;
      default: state_next = LOAD;
    endcase
  end

  // Per-state outputs; the candidate defaults to the current best pair
  always_comb begin
    buf_we   = 1'b0;
    eval_req = 1'b0;
    DONE     = 1'b0;
    eval_c1x = C1X;
    eval_c1y = C1Y;
    eval_c2x = C2X;
    eval_c2y = C2Y;
    case (state)
      LOAD:   buf_we = in_valid;
      SWEEP1: begin
        eval_req = 1'b1;
        eval_c1x = scan[3:0];
        eval_c1y = scan[7:4];
      end
      SWEEP2: begin
        eval_req = 1'b1;
        eval_c2x = scan[3:0];
        eval_c2y = scan[7:4];
      end
      FINISH: DONE = 1'b1;
      default: ;
    endcase
  end

  // Load counter, scan position, pass bookkeeping and best-pair registers
  always_ff @(posedge CLK) begin
    if (RST) begin
      load_cnt  <= '0;
      scan      <= '0;
      pass_cnt  <= '0;
      improved  <= 1'b0;
      C1X       <= '0;
      C1Y       <= '0;
      C2X       <= '0;
      C2Y       <= '0;
      best_hits <= '0;
    end else begin
      case (state)
        LOAD: if (in_valid) begin
          if (load_last) begin
            load_cnt  <= '0;
            scan      <= '0;
            pass_cnt  <= '0;
            improved  <= 1'b0;
            C1X       <= '0;
            C1Y       <= '0;
            C2X       <= '1;
            C2Y       <= '1;
            best_hits <= '0;
          end else begin
            load_cnt <= load_cnt + 6'd1;
          end
        end
        SWEEP1, SWEEP2: if (ack_fire) begin
          scan <= scan + 8'd1;
          if (better) begin
            best_hits <= eval_hits;
            improved  <= 1'b1;
            if (state == SWEEP1) {C1Y, C1X} <= scan;
            else                 {C2Y, C2X} <= scan;
          end
        end
        CHECK: begin
          pass_cnt <= pass_cnt + 8'd1;
          if (!check_stop) improved <= 1'b0;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_laser_search_ctrl.sv
// Bench for laser_search_ctrl: a datapath responder with random ack delays
// and stray acks, checked against a pass/sweep-level reference search.
module tb_laser_search_ctrl;

  localparam int NPTS     = 40;
  localparam int MAX_PASS = 4;

  logic       CLK = 1'b0;
  logic       RST = 1'b1;
  logic       in_valid = 1'b0;
  logic       eval_ack = 1'b0;
  logic [5:0] eval_hits = '0;
  logic       buf_we;
  logic [5:0] buf_addr;
  logic       eval_req;
  logic [3:0] eval_c1x, eval_c1y, eval_c2x, eval_c2y;
  logic [3:0] C1X, C1Y, C2X, C2Y;
  logic [5:0] best_hits;
  logic       DONE;

  laser_search_ctrl #(.NPTS(NPTS), .MAX_PASS(MAX_PASS)) dut (
    .CLK(CLK), .RST(RST), .in_valid(in_valid),
    .buf_we(buf_we), .buf_addr(buf_addr),
    .eval_req(eval_req),
    .eval_c1x(eval_c1x), .eval_c1y(eval_c1y), .eval_c2x(eval_c2x), .eval_c2y(eval_c2y),
    .eval_ack(eval_ack), .eval_hits(eval_hits),
    .C1X(C1X), .C1Y(C1Y), .C2X(C2X), .C2Y(C2Y),
    .best_hits(best_hits), .DONE(DONE)
  );

  always #5 CLK = ~CLK;

`ifdef LASER_EARLY_EXIT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  int n_pass  = 0;
  int n_total = 0;

  logic [15:0] exp_q[$];
  int exp_c1x, exp_c1y, exp_c2x, exp_c2y, exp_best, exp_acks;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Datapath stand-ins: hit count as a function of the candidate pair
  function automatic int model_hits(input int s, input int a, input int b, input int c, input int d);
    case (s)
      0: return 0;
      1: return (a == 5 && b == 7) ? 40 : 10;
      2: return ((a == 3 && b == 2) || (a == 9 && b == 9)) ? 20 : ((a + d) % 20);
      3: begin
        // staircase: each sweep can step one column lower for a higher score
        if (a + 1 == c) return 2 * (15 - a);
        if (c + 1 == a) return 2 * (15 - c) + 1;
        return 0;
      end
      default: return (a * 7 + b * 3 + c * 5 + d * 11) % 37;
    endcase
  endfunction

  // Reference search: expected candidate sequence and final result
  task automatic build_ref(input int s);
    int  bc1x, bc1y, bc2x, bc2y, best;
    bit  imp, stop;
    bc1x = 0; bc1y = 0; bc2x = 15; bc2y = 15; best = 0; stop = 0;
    exp_q.delete();
    for (int p = 0; p < MAX_PASS && !stop; p++) begin
      imp = 0;
      for (int sw = 0; sw < 2 && !stop; sw++) begin
        for (int i = 0; i < 256 && !stop; i++) begin
          int x, y, a, b, c, d, h;
          x = i % 16; y = i / 16;
          if (sw == 0) begin a = x; b = y; c = bc2x; d = bc2y; end
          else         begin a = bc1x; b = bc1y; c = x; d = y; end
          exp_q.push_back({a[3:0], b[3:0], c[3:0], d[3:0]});
          h = model_hits(s, a, b, c, d);
          if (h > best) begin
            best = h; imp = 1;
            if (sw == 0) begin bc1x = x; bc1y = y; end
            else         begin bc2x = x; bc2y = y; end
            if (EARLY && best == NPTS) stop = 1;
          end
        end
      end
      if (!imp) stop = 1;
    end
    exp_c1x = bc1x; exp_c1y = bc1y; exp_c2x = bc2x; exp_c2y = bc2y;
    exp_best = best; exp_acks = exp_q.size();
  endtask

  task automatic do_load();
    for (int i = 0; i < NPTS; i++) begin
      int gap;
      gap = $urandom_range(0, 2);
      repeat (gap) begin
        @(negedge CLK); in_valid = 1'b0; #1;
        chk("load_gap_we", buf_we, 0);
        chk("load_gap_addr", buf_addr, i);
      end
      @(negedge CLK); in_valid = 1'b1; #1;
      chk("load_we", buf_we, 1);
      chk("load_addr", buf_addr, i);
      chk("load_req", eval_req, 0);
    end
    @(negedge CLK); in_valid = 1'b0; #1;
    chk("sweep_start_req", eval_req, 1);
    chk("sweep_start_cand", {eval_c1x, eval_c1y, eval_c2x, eval_c2y}, 16'h00FF);
  endtask

  // Drive the datapath handshake until DONE; abort_after>=0 stops before that ack
  task automatic run_search(input int s, input int maxdly, input int abort_after);
    int acks, cyc, dly, last_ack;
    bit fin;
    logic [15:0] cand;
    acks = 0; cyc = 0; last_ack = -100; fin = 0;
    dly = $urandom_range(0, maxdly);
    while (!fin && cyc < 30000) begin
      chk("search_we", buf_we, 0);
      if (DONE) begin
        fin = 1;
      end else begin
        eval_ack  = 1'b0;
        eval_hits = 6'($urandom_range(0, 63));
        in_valid  = 1'($urandom_range(0, 1));
        if (eval_req) begin
          cand = {eval_c1x, eval_c1y, eval_c2x, eval_c2y};
          if (exp_q.size() == 0) begin
            chk("extra_cand", cand, 32'hFFFF_FFFF);
            cyc = 30000;
          end else begin
            chk("cand", cand, exp_q[0]);
            if (acks == abort_after) return;
            if (dly == 0) begin
              logic [15:0] e;
              e = exp_q.pop_front();
              eval_ack  = 1'b1;
              eval_hits = 6'(model_hits(s, int'(e[15:12]), int'(e[11:8]), int'(e[7:4]), int'(e[3:0])));
              acks++;
              last_ack = cyc;
              dly = $urandom_range(0, maxdly);
            end else begin
              dly--;
            end
          end
        end else begin
          eval_ack  = 1'($urandom_range(0, 1));
          eval_hits = 6'd63;
        end
        @(negedge CLK); #1;
        cyc++;
      end
    end
    chk("done_reached", fin, 1);
    chk("done_latency", cyc - last_ack, 2);
    chk("ack_count", acks, exp_acks);
    chk("done_req", eval_req, 0);
    chk("C1X", C1X, exp_c1x);
    chk("C1Y", C1Y, exp_c1y);
    chk("C2X", C2X, exp_c2x);
    chk("C2Y", C2Y, exp_c2y);
    chk("best_hits", best_hits, exp_best);
    eval_ack = 1'b0; in_valid = 1'b0;
    @(negedge CLK); #1;
    chk("done_pulse", DONE, 0);
    chk("post_addr", buf_addr, 0);
    chk("post_req", eval_req, 0);
    chk("hold_result", {C1X, C1Y, C2X, C2Y, 2'b00, best_hits},
        {exp_c1x[3:0], exp_c1y[3:0], exp_c2x[3:0], exp_c2y[3:0], 2'b00, 6'(exp_best)});
  endtask

  task automatic run_case(input int s, input int maxdly);
    build_ref(s);
    do_load();
    run_search(s, maxdly, -1);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk(tag, {C1X, C1Y, C2X, C2Y, best_hits, buf_addr, DONE, eval_req, buf_we}, '0);
  endtask

  initial begin
    repeat (3) @(negedge CLK);
    #1;
    chk_reset_vals("reset_vals");
    RST = 1'b0;
    @(negedge CLK); #1;
    chk_reset_vals("after_release");

    run_case(0, 0);   // no improvement: single pass
    run_case(1, 0);   // unique full cover at C1=(5,7)
    run_case(2, 0);   // tie: earlier candidate retained
    run_case(3, 0);   // staircase: pass limit ends the search
    run_case(3, 5);   // same with random ack delays
    run_case(4, 3);

    // reset in SWEEP2 with a request pending, then a late ack
    build_ref(4);
    do_load();
    run_search(4, 1, 300);
    RST = 1'b1; eval_ack = 1'b1; eval_hits = 6'd63; in_valid = 1'b0;
    @(negedge CLK); #1;
    chk_reset_vals("mid_reset");
    RST = 1'b0;
    @(negedge CLK); #1;
    chk_reset_vals("late_ack_ignored");
    eval_ack = 1'b0;
    run_case(1, 2);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
